// File: rtl/flt2int_pkg.sv
// Shared constants and state encoding for the half-precision to int16 converter.
package flt2int_pkg;

  localparam int F2I_BIAS  = 15;
  localparam int F2I_MAN_W = 10;
  localparam int F2I_EXP_W = 5;

  localparam logic [15:0] F2I_POS_SAT = 16'h7FFF;
  localparam logic [15:0] F2I_NEG_SAT = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_LO,
    DECODE,
    SHIFT,
    NEGATE,
    WR_HI,
    WR_LO
  } f2i_state_t;

endpackage

// File: rtl/flt2int_decode.sv
// Splits a half-precision float into fields and classifies it as zero,
// saturating or shiftable, giving the shifter's preload, count and direction.
module flt2int_decode
  import flt2int_pkg::*;
(
  input  logic [15:0] f,
  output logic [15:0] preload,
  output logic [3:0]  n,
  output logic        dir_left,
  output logic        neg
);

  // Exponent at which the integer value is exactly the hidden-bit mantissa.
  localparam logic [F2I_EXP_W-1:0] E_UNITY = F2I_EXP_W'(F2I_BIAS + F2I_MAN_W);
  localparam logic [F2I_EXP_W-1:0] E_ONE   = F2I_EXP_W'(F2I_BIAS);
  localparam logic [F2I_EXP_W-1:0] E_SAT   = F2I_EXP_W'(F2I_BIAS + 15);

  logic                 sign;
  logic [F2I_EXP_W-1:0] exp_f;
  logic [F2I_MAN_W-1:0] man;

  assign sign  = f[15];
  assign exp_f = f[F2I_MAN_W +: F2I_EXP_W];
  assign man   = f[F2I_MAN_W-1:0];

  always_comb begin
    preload  = '0;
    n        = '0;
    dir_left = 1'b0;
    neg      = 1'b0;
    if (exp_f == '0 || exp_f < E_ONE) begin
      preload = '0;
    end else if (exp_f >= E_SAT) begin
      // Covers |x| >= 2^15 and Inf/NaN; -32768 lands here exactly.
      preload = sign ? F2I_NEG_SAT : F2I_POS_SAT;
    end else begin
      preload = {5'b0, 1'b1, man};
      neg     = sign;
      if (exp_f > E_UNITY) begin
        dir_left = 1'b1;
        n        = 4'(exp_f - E_UNITY);
      end else begin
        n        = 4'(E_UNITY - exp_f);
      end
    end
  end

endmodule

// File: rtl/flt2int_seq.sv
// Sequential float16 -> int16 converter: reads two bytes, shifts one bit per
// cycle, optionally negates, writes two bytes back and raises ack.
module flt2int_seq
  import flt2int_pkg::*;
#(
  parameter logic [7:0] SRC_ADDR = 8'd4,
  parameter logic [7:0] DST_ADDR = 8'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       ack,
  output logic [7:0] DataAddress,
  output logic       ReadMem,
  output logic       WriteMem,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut
);

  f2i_state_t  state_reg;
  logic [15:0] f_reg;
  logic [15:0] val_reg;
  logic [3:0]  n_reg;
  logic        dir_left_reg;
  logic        neg_reg;

  logic [15:0] dec_preload;
  logic [3:0]  dec_n;
  logic        dec_dir_left;
  logic        dec_neg;
  logic [15:0] val_next;

  flt2int_decode u_decode (
    .f        (f_reg),
    .preload  (dec_preload),
    .n        (dec_n),
    .dir_left (dec_dir_left),
    .neg      (dec_neg)
  );

  assign val_next = neg_reg ? (~val_reg + 16'd1) : val_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      f_reg        <= '0;
      val_reg      <= '0;
      n_reg        <= '0;
      dir_left_reg <= 1'b0;
      neg_reg      <= 1'b0;
      ack          <= 1'b0;
      DataAddress  <= '0;
      ReadMem      <= 1'b0;
      WriteMem     <= 1'b0;
      DataIn       <= '0;
    end else if (req) begin
      // A new request abandons whatever was in flight, including a pending write.
      state_reg   <= RD_HI;
      ack         <= 1'b0;
      DataAddress <= SRC_ADDR;
      ReadMem     <= 1'b1;
      WriteMem    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ReadMem  <= 1'b0;
          WriteMem <= 1'b0;
        end
        RD_HI: begin
          f_reg[15:8] <= DataOut;
          DataAddress <= SRC_ADDR + 8'd1;
          state_reg   <= RD_LO;
        end
        RD_LO: begin
          f_reg[7:0] <= DataOut;
          ReadMem    <= 1'b0;
          state_reg  <= DECODE;
        end
        DECODE: begin
          val_reg      <= dec_preload;
          n_reg        <= dec_n;
          dir_left_reg <= dec_dir_left;
          neg_reg      <= dec_neg;
          state_reg    <= (dec_n != '0) ? SHIFT : NEGATE;
        end
        SHIFT: begin
          val_reg <= dir_left_reg ? (val_reg << 1) : (val_reg >> 1);
          n_reg   <= n_reg - 4'd1;
          if (n_reg == 4'd1) state_reg <= NEGATE;
        end
        NEGATE: begin
          // Strobes are registered, so the high byte is staged from the negated value now.
          val_reg     <= val_next;
          DataAddress <= DST_ADDR;
          DataIn      <= val_next[15:8];
          WriteMem    <= 1'b1;
          state_reg   <= WR_HI;
        end
        WR_HI: begin
          DataAddress <= DST_ADDR + 8'd1;
          DataIn      <= val_reg[7:0];
          state_reg   <= WR_LO;
        end
        WR_LO: begin
          WriteMem  <= 1'b0;
          ack       <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flt2int_seq.sv
// Bench for flt2int_seq: byte memory model, real-arithmetic reference, directed
// and random conversions, restart and mid-operation reset scenarios.
module tb_flt2int_seq;

  localparam int SRC = 4;
  localparam int DST = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       ack;
  logic [7:0] DataAddress;
  logic       ReadMem;
  logic       WriteMem;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [256];

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t wlog[$];

  flt2int_seq #(.SRC_ADDR(8'd4), .DST_ADDR(8'd6)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .DataAddress (DataAddress),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .DataIn      (DataIn),
    .DataOut     (DataOut)
  );

  always #5 clk = ~clk;

  assign DataOut = mem[DataAddress];

  always @(posedge clk) begin
    if (WriteMem) begin
      mem[DataAddress] = DataIn;
      wlog.push_back('{a: DataAddress, d: DataIn});
    end
  end

  // Reference: the float's real value, truncated toward zero, clamped to int16.
  function automatic logic [15:0] ref_conv(input logic [15:0] f);
    int  e;
    int  m;
    int  iv;
    real v;
    real scale;
    logic [15:0] r;
    e = int'(f[14:10]);
    m = int'(f[9:0]);
    if (e == 31) return f[15] ? 16'h8000 : 16'h7FFF;
    scale = 1.0;
    if (e == 0) begin
      v = m / 1024.0;
      for (int k = 0; k < 14; k++) scale = scale / 2.0;
    end else begin
      v = 1.0 + m / 1024.0;
      if (e > 15) for (int k = 0; k < e - 15; k++) scale = scale * 2.0;
      else        for (int k = 0; k < 15 - e; k++) scale = scale / 2.0;
    end
    v = v * scale;
    if (f[15]) v = -v;
    if (v >= 32768.0) return 16'h7FFF;
    if (v < -32768.0) return 16'h8000;
    iv = $rtoi(v);
    r  = iv[15:0];
    return r;
  endfunction

  // Cycles from the last req-high edge to ack: 6 plus one per shifter step.
  function automatic int ref_lat(input logic [15:0] f);
    int e;
    e = int'(f[14:10]) - 15;
    if (e < 0 || e >= 15) return 6;
    return 6 + ((e > 10) ? (e - 10) : (10 - e));
  endfunction

  task automatic launch(input logic [15:0] f);
    @(negedge clk);
    mem[SRC]     = f[15:8];
    mem[SRC + 1] = f[7:0];
    wlog.delete();
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_ack(output int cycles, output bit timeout);
    cycles  = 0;
    timeout = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ack) return;
    end
    timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ack, ReadMem, WriteMem} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_strobes: got ack/rd/wr=%b required 000", {ack, ReadMem, WriteMem});
    end
    n_cmp++;
    if ({DataAddress, DataIn} !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_bus: got addr=%h din=%h required 00/00", DataAddress, DataIn);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] tf  [13] = '{16'h3C00, 16'h4A40, 16'hC000, 16'h77FF, 16'h7800, 16'hF800, 16'h7C00,
                              16'h0000, 16'h8001, 16'h3BFF, 16'hFC01, 16'h6400, 16'hD640};
    logic [15:0] tex [13] = '{16'h0001, 16'h000C, 16'hFFFE, 16'h7FF0, 16'h7FFF, 16'h8000, 16'h7FFF,
                              16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0400, 16'hFF9C};
    int          tcy [13] = '{16, 13, 15, 10, 6, 6, 6, 6, 6, 6, 6, 6, 10};
    int          cyc;
    bit          to;
    logic [15:0] got;
    for (int i = 0; i < 13; i++) begin
      launch(tf[i]);
      wait_ack(cyc, to);
      got = {mem[DST], mem[DST + 1]};
      $display("directed f=%h result=%h cycles=%0d", tf[i], got, cyc);
      n_cmp++;
      if (to || cyc != tcy[i]) begin
        n_bad++;
        $display("FAIL dir_latency f=%h: got %0d cycles (timeout=%0d) required %0d", tf[i], cyc, to, tcy[i]);
      end
      n_cmp++;
      if (got !== tex[i]) begin
        n_bad++;
        $display("FAIL dir_result f=%h: got %h required %h", tf[i], got, tex[i]);
      end
      n_cmp++;
      if (wlog.size() != 2 || wlog[0].a !== 8'(DST) || wlog[1].a !== 8'(DST + 1)) begin
        n_bad++;
        $display("FAIL dir_writes f=%h: got %0d writes required 2 to %0d,%0d", tf[i], wlog.size(), DST, DST + 1);
      end
    end
  endtask

  // Back-to-back random requests, each issued as soon as the previous ack lands.
  task automatic test_random();
    logic [15:0] f;
    logic [15:0] got;
    logic [15:0] exp_v;
    int          cyc;
    bit          to;
    for (int i = 0; i < 60; i++) begin
      f = {1'($urandom), 5'($urandom_range(0, 31)), 10'($urandom)};
      exp_v = ref_conv(f);
      launch(f);
      wait_ack(cyc, to);
      got = {mem[DST], mem[DST + 1]};
      $display("random f=%h result=%h expected=%h cycles=%0d", f, got, exp_v, cyc);
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL rnd_result f=%h: got %h required %h", f, got, exp_v);
      end
      n_cmp++;
      if (to || cyc != ref_lat(f)) begin
        n_bad++;
        $display("FAIL rnd_latency f=%h: got %0d required %0d", f, cyc, ref_lat(f));
      end
    end
  endtask

  task automatic test_restart();
    int cyc;
    bit to;
    bit saw_one;
    @(negedge clk);
    mem[DST]     = 8'h55;
    mem[DST + 1] = 8'hAA;
    launch(16'h3C00);
    repeat (5) @(posedge clk);
    launch(16'hC000);
    wait_ack(cyc, to);
    saw_one = 1'b0;
    foreach (wlog[k]) if (wlog[k].d == 8'h01) saw_one = 1'b1;
    $display("restart result=%h writes=%0d cycles=%0d", {mem[DST], mem[DST + 1]}, wlog.size(), cyc);
    n_cmp++;
    if (to || cyc != 15) begin
      n_bad++;
      $display("FAIL restart_latency: got %0d (timeout=%0d) required 15", cyc, to);
    end
    n_cmp++;
    if ({mem[DST], mem[DST + 1]} !== 16'hFFFE || wlog.size() != 2 || saw_one) begin
      n_bad++;
      $display("FAIL restart_result: got %h with %0d writes (stale=%0d) required FFFE with 2", {mem[DST], mem[DST + 1]}, wlog.size(), saw_one);
    end
  endtask

  task automatic test_reset_mid();
    int          cyc;
    bit          to;
    logic [15:0] got;
    @(negedge clk);
    mem[DST]     = 8'h12;
    mem[DST + 1] = 8'h34;
    launch(16'h3C00);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    $display("reset_mid ack=%b rd=%b wr=%b addr=%h", ack, ReadMem, WriteMem, DataAddress);
    n_cmp++;
    if ({ack, ReadMem, WriteMem} !== 3'b000 || DataAddress !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid_now: got ack/rd/wr=%b addr=%h required 000/00", {ack, ReadMem, WriteMem}, DataAddress);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if ({mem[DST], mem[DST + 1]} !== 16'h1234 || wlog.size() != 0 || ack !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_dst: got %h writes=%0d ack=%b required 1234 0 0", {mem[DST], mem[DST + 1]}, wlog.size(), ack);
    end
    launch(16'h4A40);
    wait_ack(cyc, to);
    got = {mem[DST], mem[DST + 1]};
    $display("after_reset result=%h cycles=%0d", got, cyc);
    n_cmp++;
    if (to || got !== 16'h000C) begin
      n_bad++;
      $display("FAIL reset_mid_next: got %h (timeout=%0d) required 000C", got, to);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
